// File: rtl/instruction_memory_lineport.sv
// Clocked RV32IM instruction memory: returns a LINE_WORDS-wide line LATENCY cycles after a request is accepted.
// Define IMEM_LOAD_PORT_EN to add the program-load write port (LOAD_EN/LOAD_ADDR/LOAD_DATA).
module instruction_memory_lineport #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 256,
  parameter int    LINE_WORDS  = 1,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = "",
  localparam int   IDX_W       = $clog2(DEPTH_WORDS),
  localparam int   CNT_W       = $clog2(LATENCY) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic [ADDR_WIDTH-1:0]    ADDRESS,
`ifdef IMEM_LOAD_PORT_EN
  input  logic                     LOAD_EN,
  input  logic [IDX_W-1:0]         LOAD_ADDR,
  input  logic [31:0]              LOAD_DATA,
`endif
  output logic                     BUSYWAIT,
  output logic                     RVALID,
  output logic [32*LINE_WORDS-1:0] READINST,
  output logic                     ADDR_FAULT,
  output logic [0:0]               o_dbg_state
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [0:0]  IDLE = 1'b0;
  localparam logic [0:0]  WAIT = 1'b1;

  logic [31:0]              r_mem [DEPTH_WORDS];
  logic [0:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_widx;
  logic                     r_fault;
  logic                     r_rvalid;
  logic                     r_addr_fault;
  logic [32*LINE_WORDS-1:0] r_readinst;

  logic [IDX_W-1:0]         w_widx;
  logic                     w_hi;
  logic                     w_fault;
  logic [32*LINE_WORDS-1:0] w_line;

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = NOP;
  end

  generate
    if (ADDR_WIDTH > 2 + IDX_W) begin : g_hi
      assign w_hi = |ADDRESS[ADDR_WIDTH-1:2+IDX_W];
    end else begin : g_no_hi
      assign w_hi = 1'b0;
    end
  endgenerate

  // Line-aligned word index; anything beyond the array faults rather than wrapping.
  assign w_widx  = ADDRESS[2 +: IDX_W] & ~IDX_W'(LINE_WORDS - 1);
  assign w_fault = (ADDRESS[1:0] != 2'b00) | w_hi;

  always_comb begin
    w_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      w_line[32*i +: 32] = r_mem[r_widx + IDX_W'(i)];
    end
  end

  // Handshake: a request is taken at an edge where READ=1 in IDLE; BUSYWAIT stalls the
  // requester until the RVALID cycle, where READINST/ADDR_FAULT are valid for exactly one cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rvalid     <= 1'b0;
      r_addr_fault <= 1'b0;
      r_readinst   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (READ) begin
            r_widx  <= w_widx;
            r_fault <= w_fault;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_readinst   <= r_fault ? {LINE_WORDS{NOP}} : w_line;
            r_addr_fault <= r_fault;
            r_rvalid     <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOAD_PORT_EN
  // Storage is written after the line mux samples it, so a colliding read sees the old word.
  always_ff @(posedge CLK) begin
    if (RESET && LOAD_EN) r_mem[LOAD_ADDR] <= LOAD_DATA;
  end
`endif

  assign BUSYWAIT    = (r_state == WAIT) | ((r_state == IDLE) & READ & ~r_rvalid);
  assign RVALID      = r_rvalid;
  assign READINST    = r_readinst;
  assign ADDR_FAULT  = r_addr_fault;
  assign o_dbg_state = r_state;

endmodule
